// File: rtl/fsm_table_ctrl.sv
// -----------------------------------------------------------------------------
// fsm_table_ctrl
//   Table-programmed control automaton. A {state, x} indexed table holds, for
//   each state/condition pair, the next state and the command word to drive.
//   The table is loaded through a small config port while the automaton is
//   stopped. The block also provides single stepping, optionally registered
//   command outputs, a self-loop dwell watchdog and a sticky fault state.
//
// Parameters
//   SW        state register width (2^SW states)
//   NX        condition input width
//   NT        command output width
//   DW        dwell counter / dwell_max width
//   OUT_REG   0: t combinational (Mealy), 1: t registered (one clock later)
//   ERR_STATE state forced when the watchdog trips
//
// Ports
//   clk        rising-edge clock
//   res_n      asynchronous active-low reset
//   run        advance every cycle
//   step       with run=0, advance once per high cycle
//   x          condition inputs
//   t          command outputs
//   state      current state
//   cfg_we     table write strobe (honoured only while run=0 and step=0)
//   cfg_addr   table index {state, x}
//   cfg_data   table entry {next, cmd}
//   cfg_rdata  entry at cfg_addr, registered, read-before-write
//   cfg_rej    one-cycle pulse after a write attempted while running/stepping
//   dwell_max  self-loop limit, 0 disables the watchdog
//   fault      sticky watchdog fault
//   clr_fault  clears fault and the dwell counter
// -----------------------------------------------------------------------------
module fsm_table_ctrl #(
    parameter int SW        = 4,
    parameter int NX        = 2,
    parameter int NT        = 9,
    parameter int DW        = 8,
    parameter bit OUT_REG   = 1'b0,
    parameter int ERR_STATE = 15
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 run,
    input  logic                 step,
    input  logic [NX-1:0]        x,
    output logic [NT-1:0]        t,
    output logic [SW-1:0]        state,
    input  logic                 cfg_we,
    input  logic [SW+NX-1:0]     cfg_addr,
    input  logic [SW+NT-1:0]     cfg_data,
    output logic [SW+NT-1:0]     cfg_rdata,
    output logic                 cfg_rej,
    input  logic [DW-1:0]        dwell_max,
    output logic                 fault,
    input  logic                 clr_fault
);

    localparam int AW    = SW + NX;
    localparam int EW    = SW + NT;
    localparam int DEPTH = 1 << AW;

    // Transition/command table. Every entry must clear on reset, so this is
    // a register array rather than a block RAM.
    logic [EW-1:0] tbl_reg [DEPTH];

    logic [SW-1:0] state_reg;
    logic          fault_reg;
    logic [DW-1:0] cnt_reg;
    logic          cfg_rej_reg;
    logic [EW-1:0] cfg_rdata_reg;

    logic          adv;
    logic          wr_en;
    logic [EW-1:0] entry;
    logic [SW-1:0] e_next;
    logic [NT-1:0] e_cmd;
    logic [NT-1:0] cmd_now;
    logic          self_loop;
    logic [DW:0]   cnt_inc;
    logic [DW-1:0] cnt_sat;
    logic          trip;

    assign adv       = (run | step) & ~fault_reg;
    assign wr_en     = cfg_we & ~run & ~step;
    assign entry     = tbl_reg[{state_reg, x}];
    assign e_next    = entry[EW-1:NT];
    assign e_cmd     = entry[NT-1:0];
    assign cmd_now   = adv ? e_cmd : '0;
    assign self_loop = (e_next == state_reg);

    // Extra bit on the increment so a saturated counter never matches a
    // dwell_max of all-ones by wrapping.
    assign cnt_inc = {1'b0, cnt_reg} + 1'b1;
    assign cnt_sat = (&cnt_reg) ? cnt_reg : cnt_inc[DW-1:0];
    assign trip    = (dwell_max != '0) && adv && self_loop
                     && (cnt_inc == {1'b0, dwell_max});

    // Table storage
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_reg[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_reg[cfg_addr] <= cfg_data;
        end
    end

    // Automaton state, watchdog and config handshake
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg     <= '0;
            fault_reg     <= 1'b0;
            cnt_reg       <= '0;
            cfg_rej_reg   <= 1'b0;
            cfg_rdata_reg <= '0;
        end else begin
            cfg_rej_reg   <= cfg_we & (run | step);
            // Nonblocking read of the array gives old data on a same-address write.
            cfg_rdata_reg <= tbl_reg[cfg_addr];

            if (trip) begin
                // Trip overrides both the table next-state and a same-edge clear.
                state_reg <= SW'(ERR_STATE);
                fault_reg <= 1'b1;
                cnt_reg   <= '0;
            end else begin
                if (adv) begin
                    state_reg <= e_next;
                    cnt_reg   <= self_loop ? cnt_sat : '0;
                end
                if (clr_fault) begin
                    fault_reg <= 1'b0;
                    cnt_reg   <= '0;
                end
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [NT-1:0] t_reg;
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    t_reg <= '0;
                end else begin
                    t_reg <= cmd_now;
                end
            end
            assign t = t_reg;
        end else begin : g_out_comb
            assign t = cmd_now;
        end
    endgenerate

    assign state     = state_reg;
    assign fault     = fault_reg;
    assign cfg_rej   = cfg_rej_reg;
    assign cfg_rdata = cfg_rdata_reg;

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fsm_table_ctrl
//   Drives two instances of fsm_table_ctrl from the same inputs: one with
//   combinational commands (OUT_REG=0) and one with registered commands
//   (OUT_REG=1). Inputs change 1 time unit after a rising edge; outputs are
//   sampled before the next edge (combinational view) and 1 unit after it
//   (registered view).
// -----------------------------------------------------------------------------
module tb_fsm_table_ctrl;

    logic        clk = 1'b0;
    logic        res_n;
    logic        run, step, cfg_we, clr_fault;
    logic [1:0]  x;
    logic [5:0]  cfg_addr;
    logic [12:0] cfg_data;
    logic [7:0]  dwell_max;

    logic [8:0]  t0, t1;
    logic [3:0]  state0, state1;
    logic [12:0] rdata0, rdata1;
    logic        rej0, rej1, fault0, fault1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic [1:0] x;
        logic [3:0] s_pre;   // state before the edge
        logic [8:0] t0;      // combinational t before the edge
        logic [3:0] s_post;  // state after the edge
        logic [8:0] t1;      // registered t after the edge
        logic       fault;   // fault after the edge
    } vec_t;

    vec_t ring_vecs[$];
    vec_t step_vecs[$];
    vec_t fault_vecs[$];

    always #5 clk = ~clk;

    fsm_table_ctrl #(.OUT_REG(1'b0)) dut0 (
        .clk(clk), .res_n(res_n), .run(run), .step(step), .x(x), .t(t0),
        .state(state0), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_rdata(rdata0), .cfg_rej(rej0), .dwell_max(dwell_max),
        .fault(fault0), .clr_fault(clr_fault)
    );

    fsm_table_ctrl #(.OUT_REG(1'b1)) dut1 (
        .clk(clk), .res_n(res_n), .run(run), .step(step), .x(x), .t(t1),
        .state(state1), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_rdata(rdata1), .cfg_rej(rej1), .dwell_max(dwell_max),
        .fault(fault1), .clr_fault(clr_fault)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] xv,
                                input logic [3:0] sp, input logic [8:0] ta,
                                input logic [3:0] sn, input logic [8:0] tb,
                                input logic f);
        vec_t v;
        v.run = r; v.step = s; v.x = xv; v.s_pre = sp; v.t0 = ta;
        v.s_post = sn; v.t1 = tb; v.fault = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        run = v.run; step = v.step; x = v.x;
        #1;
        check({name, " state_pre"}, 32'(state0), 32'(v.s_pre));
        check({name, " t_comb"}, 32'(t0), 32'(v.t0));
        tick();
        check({name, " state_post"}, 32'({state0, state1}), 32'({v.s_post, v.s_post}));
        check({name, " t_reg"}, 32'(t1), 32'(v.t1));
        check({name, " fault"}, 32'({fault0, fault1}), 32'({v.fault, v.fault}));
    endtask

    task automatic cfg_write(input logic [3:0] s, input logic [1:0] xv,
                             input logic [3:0] nxt, input logic [8:0] cmd);
        run = 1'b0; step = 1'b0;
        cfg_we = 1'b1; cfg_addr = {s, xv}; cfg_data = {nxt, cmd};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic program_ring();
        for (int s = 0; s < 3; s++) begin
            for (int xi = 0; xi < 4; xi++) begin
                cfg_write(4'(s), 2'(xi), 4'((s + 1) % 3), 9'(s + 1));
            end
        end
    endtask

    initial begin
        // Ring: 0->1->2->0 with cmd = state+1
        ring_vecs.push_back(mk(1, 0, 2'd0, 0, 1, 1, 1, 0));
        ring_vecs.push_back(mk(1, 0, 2'd1, 1, 2, 2, 2, 0));
        ring_vecs.push_back(mk(1, 0, 2'd2, 2, 3, 0, 3, 0));
        ring_vecs.push_back(mk(1, 0, 2'd3, 0, 1, 1, 1, 0));
        ring_vecs.push_back(mk(0, 0, 2'd0, 1, 0, 1, 0, 0));
        // Stepping: two single steps 5 idle cycles apart, run+step, held step
        step_vecs.push_back(mk(0, 1, 2'd0, 1, 2, 2, 2, 0));
        for (int i = 0; i < 5; i++) step_vecs.push_back(mk(0, 0, 2'd1, 2, 0, 2, 0, 0));
        step_vecs.push_back(mk(0, 1, 2'd3, 2, 3, 0, 3, 0));
        step_vecs.push_back(mk(0, 0, 2'd0, 0, 0, 0, 0, 0));
        step_vecs.push_back(mk(1, 1, 2'd1, 0, 1, 1, 1, 0));
        step_vecs.push_back(mk(0, 0, 2'd0, 1, 0, 1, 0, 0));
        step_vecs.push_back(mk(0, 1, 2'd0, 1, 2, 2, 2, 0));
        step_vecs.push_back(mk(0, 1, 2'd0, 2, 3, 0, 3, 0));
        step_vecs.push_back(mk(0, 0, 2'd0, 0, 0, 0, 0, 0));
        // Watchdog with dwell_max=3 from state 0 via x=11 into self-loop state 5
        fault_vecs.push_back(mk(0, 1, 2'd3, 0, 9'h011, 5, 9'h011, 0));
        fault_vecs.push_back(mk(1, 0, 2'd1, 5, 9'h0A5, 5, 9'h0A5, 0));
        fault_vecs.push_back(mk(1, 0, 2'd1, 5, 9'h0A5, 5, 9'h0A5, 0));
        fault_vecs.push_back(mk(1, 0, 2'd1, 5, 9'h0A5, 15, 9'h0A5, 1));
        fault_vecs.push_back(mk(1, 0, 2'd1, 15, 0, 15, 0, 1));
        fault_vecs.push_back(mk(1, 0, 2'd0, 15, 0, 15, 0, 1));

        res_n = 1'b0; run = 1'b0; step = 1'b0; cfg_we = 1'b0; clr_fault = 1'b0;
        x = '0; cfg_addr = '0; cfg_data = '0; dwell_max = '0;

        // ---- 1: reset, then reset mid-run ----
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        check("reset state", 32'({state0, state1}), 32'h0);
        check("reset t", 32'({t0, t1}), 32'h0);
        check("reset fault", 32'({fault0, fault1}), 32'h0);
        check("reset cfg_rej", 32'({rej0, rej1}), 32'h0);
        check("reset cfg_rdata", 32'(rdata0), 32'h0);
        program_ring();
        run = 1'b1;
        tick();
        tick();
        check("pre-reset state", 32'(state0), 32'd2);
        #2 res_n = 1'b0;
        #1;
        check("midrun reset state", 32'({state0, state1}), 32'h0);
        check("midrun reset t", 32'({t0, t1}), 32'h0);
        check("midrun reset fault", 32'({fault0, fault1}), 32'h0);
        run = 1'b0;
        tick();
        res_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            cfg_addr = 6'(a);
            tick();
            check($sformatf("table cleared @%0d", a), 32'(rdata0), 32'h0);
        end

        // ---- 2: ring ----
        program_ring();
        for (int i = 0; i < ring_vecs.size(); i++)
            apply_vec(ring_vecs[i], $sformatf("ring[%0d]", i));

        // ---- 3: stepping ----
        for (int i = 0; i < step_vecs.size(); i++)
            apply_vec(step_vecs[i], $sformatf("step[%0d]", i));

        // ---- 4: dwell watchdog ----
        dwell_max = 8'd3;
        cfg_write(4'd0, 2'd3, 4'd5, 9'h011);
        cfg_write(4'd5, 2'd1, 4'd5, 9'h0A5);
        for (int i = 0; i < fault_vecs.size(); i++)
            apply_vec(fault_vecs[i], $sformatf("wdog[%0d]", i));
        clr_fault = 1'b1;
        apply_vec(mk(0, 0, 2'd0, 15, 0, 15, 0, 0), "clr_fault");
        clr_fault = 1'b0;
        dwell_max = 8'd0;
        cfg_write(4'd15, 2'd2, 4'd5, 9'h015);
        apply_vec(mk(0, 1, 2'd2, 15, 9'h015, 5, 9'h015, 0), "leave err");
        for (int i = 0; i < 10; i++)
            apply_vec(mk(1, 0, 2'd1, 5, 9'h0A5, 5, 9'h0A5, 0), $sformatf("wdog off[%0d]", i));

        // ---- 5: write rejection and read-before-write ----
        run = 1'b1; step = 1'b0; x = 2'd1;
        cfg_we = 1'b1; cfg_addr = 6'b0001_00; cfg_data = {4'd7, 9'h1FF};
        tick();
        check("rej while run", 32'({rej0, rej1}), 32'h3);
        check("rdata after rej", 32'(rdata0), 32'h402);
        cfg_we = 1'b0; run = 1'b0;
        tick();
        check("rej pulse width", 32'(rej0), 32'h0);
        check("rdata unchanged", 32'(rdata0), 32'h402);
        cfg_we = 1'b1; step = 1'b1;
        tick();
        check("rej while step", 32'(rej0), 32'h1);
        check("rdata unchanged step", 32'(rdata0), 32'h402);
        step = 1'b0;
        tick();
        check("accepted write no rej", 32'(rej0), 32'h0);
        check("read-before-write", 32'(rdata0), 32'h402);
        cfg_we = 1'b0;
        tick();
        check("readback new", 32'({rdata0, rdata1}), 32'({13'hFFF, 13'hFFF}));

        // ---- 6: set/clear collision, x-selected entries ----
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        dwell_max = 8'd2;
        apply_vec(mk(1, 0, 2'd1, 5, 9'h0A5, 5, 9'h0A5, 0), "dwell2 first");
        clr_fault = 1'b1;
        apply_vec(mk(1, 0, 2'd1, 5, 9'h0A5, 15, 9'h0A5, 1), "set wins over clr");
        apply_vec(mk(0, 0, 2'd0, 15, 0, 15, 0, 0), "clr after collision");
        clr_fault = 1'b0;
        dwell_max = 8'd0;
        cfg_write(4'd15, 2'd0, 4'd3, 9'h1F0);
        cfg_write(4'd3, 2'd0, 4'd4, 9'h100);
        cfg_write(4'd3, 2'd1, 4'd6, 9'h0C3);
        cfg_write(4'd6, 2'd0, 4'd3, 9'h036);
        apply_vec(mk(0, 1, 2'd0, 15, 9'h1F0, 3, 9'h1F0, 0), "to state3");
        x = 2'd0; step = 1'b1;
        #1 check("x=00 entry cmd", 32'(t0), 32'h100);
        apply_vec(mk(0, 1, 2'd1, 3, 9'h0C3, 6, 9'h0C3, 0), "x=01 entry");
        apply_vec(mk(0, 1, 2'd0, 6, 9'h036, 3, 9'h036, 0), "back to 3");
        apply_vec(mk(0, 1, 2'd0, 3, 9'h100, 4, 9'h100, 0), "x=00 entry");
        apply_vec(mk(0, 0, 2'd0, 4, 0, 4, 0, 0), "idle end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
